// File: rtl/imem_if.sv
// imem_if: fetch request/response, flush and program-load signals between the core and imem_resp
interface imem_if #(
  parameter int W = 32
) ();
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_addr;
  logic         flush;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_inst;
  logic [W-1:0] rsp_addr;
  logic         rsp_err;
  logic         wr_en;
  logic [W-1:0] wr_addr;
  logic [W-1:0] wr_data;

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );

  modport master (
    output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_resp.sv
// imem_resp: instruction memory with fixed-latency read pipeline and an in-order response FIFO
module imem_resp #(
  parameter int                   CPU_WIDTH   = 32,
  parameter int                   DEPTH_WORDS = 1024,
  parameter int                   LATENCY     = 2,
  parameter logic [CPU_WIDTH-1:0] NOP_INST    = 32'h0000_0013
) (
  input logic   clk_i,
  input logic   rstn_i,
  imem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int SW = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int D  = LATENCY + 1;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic [CPU_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic                 acc, pop, fw, acc_err, fw_err, unused_ok;
  logic [CPU_WIDTH-1:0] acc_inst, fw_addr, fw_inst;
  logic [SW-1:0]        pv_q, pv_d, pe_q, pe_d;
  logic [CPU_WIDTH-1:0] pa_q [SW], pa_d [SW], pi_q [SW], pi_d [SW];
  logic [CPU_WIDTH-1:0] fa_q [D], fi_q [D];
  logic [D-1:0]         fe_q;
  logic [PW-1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]        fc_q, fc_d, oc_q, oc_d;

  assign unused_ok = ^bus.wr_addr[1:0];
  // ready looks only at the registered count so a same-cycle pop never frees a slot early
  assign bus.req_ready = !bus.flush && (oc_q < CW'(D));
  assign acc           = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = fc_q != '0;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign acc_err       = (|bus.req_addr[1:0]) || (|bus.req_addr[CPU_WIDTH-1:AW+2]);
  assign acc_inst      = acc_err ? NOP_INST : mem_q[bus.req_addr[AW+1:2]];
  // with a single cycle of latency the accepted request goes straight into the FIFO
  assign fw      = (LATENCY > 1) ? pv_q[SW-1] : acc;
  assign fw_addr = (LATENCY > 1) ? pa_q[SW-1] : bus.req_addr;
  assign fw_inst = (LATENCY > 1) ? pi_q[SW-1] : acc_inst;
  assign fw_err  = (LATENCY > 1) ? pe_q[SW-1] : acc_err;
  assign bus.rsp_inst = bus.rsp_valid ? fi_q[rp_q] : '0;
  assign bus.rsp_addr = bus.rsp_valid ? fa_q[rp_q] : '0;
  assign bus.rsp_err  = bus.rsp_valid && fe_q[rp_q];

  always_comb begin
    pv_d = pv_q;
    pe_d = pe_q;
    pa_d = pa_q;
    pi_d = pi_q;
    for (int i = SW - 1; i > 0; i--) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pa_d[i] = pa_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
    pv_d[0] = acc;
    pe_d[0] = acc_err;
    pa_d[0] = bus.req_addr;
    pi_d[0] = acc_inst;
    if (bus.flush) pv_d = '0;
  end

  always_comb begin
    wp_d = (fw && wp_q == PW'(D - 1)) ? '0 : wp_q + PW'(fw);
    rp_d = (pop && rp_q == PW'(D - 1)) ? '0 : rp_q + PW'(pop);
    fc_d = fc_q + CW'(fw) - CW'(pop);
    oc_d = oc_q + CW'(acc) - CW'(pop);
    if (bus.flush) begin
      wp_d = '0;
      rp_d = '0;
      fc_d = '0;
      oc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pv_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      fc_q <= '0;
      oc_q <= '0;
    end else begin
      pv_q <= pv_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      fc_q <= fc_d;
      oc_q <= oc_d;
    end
  end

  // payload storage and memory are qualified by the valid/pointer state, so they carry no reset
  always_ff @(posedge clk_i) begin
    pe_q <= pe_d;
    pa_q <= pa_d;
    pi_q <= pi_d;
    if (fw) begin
      fa_q[wp_q] <= fw_addr;
      fi_q[wp_q] <= fw_inst;
      fe_q[wp_q] <= fw_err;
    end
    if (bus.wr_en && !(|bus.wr_addr[CPU_WIDTH-1:AW+2])) mem_q[bus.wr_addr[AW+1:2]] <= bus.wr_data;
  end
endmodule

// File: tb/tb_imem_resp.sv
// tb_imem_resp: randomized bench checking imem_resp against a queue-of-responses model
module tb_imem_resp;
  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  imem_if #(.W(32)) bus ();
  imem_resp #(.CPU_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .NOP_INST(NOP)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  logic [31:0] mem_m [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic m_valid();
    return q.size() > 0 && q[0].due <= cyc;
  endfunction

  function automatic logic m_ready();
    return !bus.flush && q.size() < LAT + 1;
  endfunction

  task automatic drive(logic v, logic [31:0] a, logic rr, logic fl, logic we, logic [31:0] wa, logic [31:0] wd);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.rsp_ready = rr;
    bus.flush     = fl;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
  endtask

  // advance one clock edge, applying the same edge to the model
  task automatic cycle();
    logic acc, pop;
    exp_t e;
    acc = bus.req_valid && m_ready();
    pop = m_valid() && bus.rsp_ready;
    e.addr = bus.req_addr;
    e.err  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr / 4 >= DEPTH);
    e.inst = e.err ? NOP : mem_m[bus.req_addr[11:2]];
    e.due  = cyc + LAT;
    if (bus.flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (bus.wr_en && bus.wr_addr[31:12] == 20'd0) mem_m[bus.wr_addr[11:2]] = bus.wr_data;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if ({bus.rsp_inst, bus.rsp_addr, bus.rsp_err} !== 65'd0) begin failures++; $display("FAIL reset_data got=%h/%h/%b exp=0/0/0", bus.rsp_inst, bus.rsp_addr, bus.rsp_err); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 64; i++) begin
      drive(0, 0, 0, 0, 1, 32'(i * 4), (i < 4) ? 32'hA000_0000 + 32'(i) : $urandom);
      cycle();
    end
    drive(0, 0, 0, 0, 1, 32'h1000, 32'hBAD0_BAD0);
    cycle();
  endtask

  task automatic test_back_to_back();
    int acc0 = -1, first = -1, last = -1, n = 0;
    for (int k = 0; k < 10; k++) begin
      drive(k < 4, 32'(k * 4), 1, 0, 0, 0, 0);
      #1;
      checks++; if (bus.req_ready !== m_ready()) begin failures++; $display("FAIL b2b_ready got=%b exp=%b", bus.req_ready, m_ready()); end
      checks++; if (bus.rsp_valid !== m_valid()) begin failures++; $display("FAIL b2b_valid got=%b exp=%b", bus.rsp_valid, m_valid()); end
      if (k == 0 && bus.req_ready) acc0 = cyc;
      if (bus.rsp_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        checks++;
        if ({bus.rsp_inst, bus.rsp_addr, bus.rsp_err} !== {32'hA000_0000 + 32'(n), 32'(n * 4), 1'b0}) begin
          failures++; $display("FAIL b2b_data got=%h/%h/%b exp=%h/%h/0", bus.rsp_inst, bus.rsp_addr, bus.rsp_err, 32'hA000_0000 + 32'(n), n * 4);
        end
        n++;
      end
      cycle();
    end
    checks++; if (first - acc0 !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", first - acc0, LAT); end
    checks++; if (n !== 4 || last - first !== 3) begin failures++; $display("FAIL b2b_stream got=%0d/%0d exp=4/3", n, last - first); end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'($urandom_range(0, 63)) << 2, 0, 0, 0, 0, 0);
      #1;
      checks++; if (bus.req_ready !== m_ready()) begin failures++; $display("FAIL bp_ready got=%b exp=%b", bus.req_ready, m_ready()); end
      checks++; if (bus.rsp_valid !== m_valid()) begin failures++; $display("FAIL bp_valid got=%b exp=%b", bus.rsp_valid, m_valid()); end
      if (bus.req_ready) n_acc++;
      cycle();
    end
    checks++; if (n_acc !== LAT + 1) begin failures++; $display("FAIL bp_accepts got=%0d exp=%0d", n_acc, LAT + 1); end
    drive(0, 0, 1, 0, 0, 0, 0);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", bus.req_ready); end
    cycle();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop got=%b exp=1", bus.req_ready); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.rsp_valid !== m_valid()) begin failures++; $display("FAIL bp_drain_valid got=%b exp=%b", bus.rsp_valid, m_valid()); end
      if (m_valid()) begin
        checks++;
        if ({bus.rsp_inst, bus.rsp_addr, bus.rsp_err} !== {q[0].inst, q[0].addr, q[0].err}) begin
          failures++; $display("FAIL bp_drain_data got=%h/%h/%b exp=%h/%h/%b", bus.rsp_inst, bus.rsp_addr, bus.rsp_err, q[0].inst, q[0].addr, q[0].err);
        end
      end
      cycle();
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [6];
    logic [64:0] fixed [3];
    int j = 0;
    addrs = '{32'h2, 32'h1000, 32'h0, (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3)), 32'hFFFF_FFFC, 32'h1FFF};
    fixed = '{{NOP, 32'h2, 1'b1}, {NOP, 32'h1000, 1'b1}, {32'hA000_0000, 32'h0, 1'b0}};
    for (int k = 0; k < 11; k++) begin
      drive(k < 6, (k < 6) ? addrs[k] : 32'h0, 1, 0, 0, 0, 0);
      #1;
      checks++; if (bus.rsp_valid !== m_valid()) begin failures++; $display("FAIL err_valid got=%b exp=%b", bus.rsp_valid, m_valid()); end
      if (m_valid()) begin
        checks++;
        if ({bus.rsp_inst, bus.rsp_addr, bus.rsp_err} !== {q[0].inst, q[0].addr, q[0].err}) begin
          failures++; $display("FAIL err_data got=%h/%h/%b exp=%h/%h/%b", bus.rsp_inst, bus.rsp_addr, bus.rsp_err, q[0].inst, q[0].addr, q[0].err);
        end
      end
      if (bus.rsp_valid) begin
        if (j < 3) begin
          checks++;
          if ({bus.rsp_inst, bus.rsp_addr, bus.rsp_err} !== fixed[j]) begin
            failures++; $display("FAIL err_fixed%0d got=%h/%h/%b exp=%h", j, bus.rsp_inst, bus.rsp_addr, bus.rsp_err, fixed[j]);
          end
        end
        j++;
      end
      cycle();
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'($urandom_range(0, 63)) << 2, 0, 0, 0, 0, 0);
      #1;
      checks++; if (bus.req_ready !== m_ready()) begin failures++; $display("FAIL fl_ready got=%b exp=%b", bus.req_ready, m_ready()); end
      cycle();
    end
    drive(1, 32'h40, 1, 1, 0, 0, 0);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL fl_ready_during got=%b exp=0", bus.req_ready); end
    cycle();
    drive(0, 0, 1, 0, 0, 0, 0);
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL fl_valid_after got=%b exp=0", bus.rsp_valid); end
    for (int k = 0; k < 6; k++) begin
      drive(k == 0, 32'h40, 1, 0, 0, 0, 0);
      #1;
      checks++; if (bus.rsp_valid !== m_valid()) begin failures++; $display("FAIL fl_post_valid got=%b exp=%b", bus.rsp_valid, m_valid()); end
      if (bus.rsp_valid) begin
        checks++;
        if ({bus.rsp_inst, bus.rsp_addr, bus.rsp_err} !== {mem_m[16], 32'h40, 1'b0}) begin
          failures++; $display("FAIL fl_post_data got=%h/%h/%b exp=%h/40/0", bus.rsp_inst, bus.rsp_addr, bus.rsp_err, mem_m[16]);
        end
      end
      cycle();
    end
  endtask

  task automatic test_collision();
    int n = 0;
    drive(0, 0, 1, 0, 1, 32'h8, 32'h1111_1111);
    cycle();
    for (int k = 0; k < 10; k++) begin
      drive(k == 0 || k == 5, 32'h8, 1, 0, k == 0, 32'h8, 32'hDEAD_BEEF);
      #1;
      checks++; if (bus.rsp_valid !== m_valid()) begin failures++; $display("FAIL col_valid got=%b exp=%b", bus.rsp_valid, m_valid()); end
      if (bus.rsp_valid) begin
        checks++;
        if (bus.rsp_inst !== ((n == 0) ? 32'h1111_1111 : 32'hDEAD_BEEF)) begin
          failures++; $display("FAIL col_inst%0d got=%h exp=%h", n, bus.rsp_inst, (n == 0) ? 32'h1111_1111 : 32'hDEAD_BEEF);
        end
        n++;
      end
      cycle();
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL col_count got=%0d exp=2", n); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int k = 0; k < 420; k++) begin
      r = $urandom_range(0, 7);
      a = (r == 0) ? ((32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3))) :
          (r == 1) ? (32'h1000 + ($urandom & 32'h0FFF_FFFC)) : (32'($urandom_range(0, 63)) << 2);
      if (k < 400)
        drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 5) == 0, ($urandom_range(0, 9) == 0) ? 32'h1000 : 32'($urandom_range(0, 255)), $urandom);
      else
        drive(0, 0, 1, 0, 0, 0, 0);
      #1;
      checks++; if (bus.req_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, bus.req_ready, m_ready()); end
      checks++; if (bus.rsp_valid !== m_valid()) begin failures++; $display("FAIL rnd_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, m_valid()); end
      if (m_valid()) begin
        checks++;
        if ({bus.rsp_inst, bus.rsp_addr, bus.rsp_err} !== {q[0].inst, q[0].addr, q[0].err}) begin
          failures++; $display("FAIL rnd_data k=%0d got=%h/%h/%b exp=%h/%h/%b", k, bus.rsp_inst, bus.rsp_addr, bus.rsp_err, q[0].inst, q[0].addr, q[0].err);
        end
      end
      cycle();
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] a;
    logic seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'($urandom_range(0, 63)) << 2, 0, 0, 0, 0, 0);
      cycle();
    end
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%b exp=1", bus.rsp_valid); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL ar_valid_immediate got=%b exp=0", bus.rsp_valid); end
    q.delete();
    drive(0, 0, 1, 0, 0, 0, 0);
    #2;
    rstn = 1'b1;
    cycle();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL ar_release got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
    a = 32'($urandom_range(0, 63)) << 2;
    for (int k = 0; k < 6; k++) begin
      drive(k == 0, a, 1, 0, 0, 0, 0);
      #1;
      checks++; if (bus.rsp_valid !== m_valid()) begin failures++; $display("FAIL ar_valid got=%b exp=%b", bus.rsp_valid, m_valid()); end
      if (bus.rsp_valid && !seen) begin
        seen = 1'b1;
        checks++;
        if ({bus.rsp_inst, bus.rsp_addr, bus.rsp_err} !== {mem_m[a[11:2]], a, 1'b0}) begin
          failures++; $display("FAIL ar_first got=%h/%h/%b exp=%h/%h/0", bus.rsp_inst, bus.rsp_addr, bus.rsp_err, mem_m[a[11:2]], a);
        end
      end
      cycle();
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL ar_no_response got=%b exp=1", seen); end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    test_reset();
    load_mem();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_flush();
    test_collision();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
